// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state encoding and defaults for the clock divider controller.
package clk_div_pkg;
    localparam int CNT_W_DEF = 28;
    localparam int MIN_DIV_DEF = 2;
    typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_e;
endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: period counter and registered waveform/tick generator.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             run,
    input  logic [CNT_W-1:0] active_div,
    output logic             clock_out,
    output logic             tick,
    output logic             boundary
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    logic             run_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, hi;
    // run is next-cycle intent, so outputs are computed for the counter value being loaded
    always_comb begin
        hi = active_div - (active_div >> 1);
        boundary = run_q && (cnt_q == active_div - ONE);
        cnt_d = (run && run_q && !boundary) ? cnt_q + ONE : '0;
    end
    always_ff @(posedge clock_in) begin
        if (reset) begin
            run_q     <= 1'b0;
            cnt_q     <= '0;
            clock_out <= 1'b0;
            tick      <= 1'b0;
        end else begin
            run_q     <= run;
            cnt_q     <= cnt_d;
            clock_out <= run && (cnt_d < hi);
            tick      <= run && (cnt_d == '0);
        end
    end
endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: start/stop sequencing and glitch-free divisor updates for the clock divider.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEFAULT_DIV = 50000000,
    parameter int MIN_DIV = MIN_DIV_DEF
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             div_valid,
    input  logic [CNT_W-1:0] div_value,
    output logic             div_ready,
    output logic             div_err,
    output logic             clock_out,
    output logic             tick,
    output logic [CNT_W-1:0] active_div,
    output logic             busy
);
    localparam logic [CNT_W-1:0] MIN_N = CNT_W'(MIN_DIV);
    state_e           state_q, state_d;
    logic             pend_q, pend_d, err_q, boundary, accept, legal;
    logic [CNT_W-1:0] shadow_q, shadow_d, active_q, active_d;
    always_comb begin
        accept = div_valid && !pend_q;
        legal = div_value >= MIN_N;
        state_d = (state_q == IDLE) ? (enable ? RUN : IDLE) : (enable ? RUN : (boundary ? IDLE : STOP_PEND));
        active_d = (pend_q && boundary) ? shadow_q : (accept && legal && state_q == IDLE) ? div_value : active_q;
        // a request landing in the boundary cycle sees pend_q low, so it waits for the next boundary
        pend_d = pend_q ? !boundary : (accept && legal && state_q != IDLE);
        shadow_d = accept ? div_value : shadow_q;
    end
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
            shadow_q <= '0;
            active_q <= CNT_W'(DEFAULT_DIV);
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            err_q    <= accept && !legal;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end
    clk_div_core #(.CNT_W(CNT_W)) u_core (
        .clock_in  (clock_in),
        .reset     (reset),
        .run       (state_d != IDLE),
        .active_div(active_q),
        .clock_out (clock_out),
        .tick      (tick),
        .boundary  (boundary)
    );
    assign div_ready  = !pend_q;
    assign div_err    = err_q;
    assign busy       = state_q != IDLE;
    assign active_div = active_q;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed checks of start/stop, divisor handshake and reset behaviour.
module tb_clk_div_ctrl;
    localparam int CNT_W = 28;
    localparam int DEF = 50000000;
    logic             clock_in = 1'b0;
    logic             reset, enable, div_valid;
    logic [CNT_W-1:0] div_value;
    logic             div_ready, div_err, clock_out, tick, busy;
    logic [CNT_W-1:0] active_div;
    logic [31:0]      c, t, r, b;
    int               n_chk = 0, n_pass = 0;

    clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF), .MIN_DIV(2)) dut (
        .clock_in  (clock_in),
        .reset     (reset),
        .enable    (enable),
        .div_valid (div_valid),
        .div_value (div_value),
        .div_ready (div_ready),
        .div_err   (div_err),
        .clock_out (clock_out),
        .tick      (tick),
        .active_div(active_div),
        .busy      (busy)
    );

    always #10 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock_in);
            #1;
        end
    endtask

    // samples n cycles MSB-first, stepping after each sample
    task automatic capture(input int n, output logic [31:0] vc, output logic [31:0] vt,
                           output logic [31:0] vr, output logic [31:0] vb);
        vc = '0; vt = '0; vr = '0; vb = '0;
        for (int i = 0; i < n; i++) begin
            vc = {vc[30:0], clock_out};
            vt = {vt[30:0], tick};
            vr = {vr[30:0], div_ready};
            vb = {vb[30:0], busy};
            step();
        end
    endtask

    task automatic request(input int v);
        div_valid = 1'b1;
        div_value = CNT_W'(v);
        step();
        div_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; div_valid = 1'b0; div_value = '0;
        step(2);
        check("rst_clk", 32'(clock_out), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_ready", 32'(div_ready), 1);
        check("rst_err", 32'(div_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_div", 32'(active_div), DEF);
        reset = 1'b0;
        step();
        request(4);
        check("idle_div4", 32'(active_div), 4);
        check("idle_ready", 32'(div_ready), 1);
        enable = 1'b1;
        step();
        check("start_clk", 32'(clock_out), 1);
        check("start_tick", 32'(tick), 1);
        check("start_busy", 32'(busy), 1);
        capture(12, c, t, r, b);
        check("n4_clk", c, 32'b110011001100);
        check("n4_tick", t, 32'b100010001000);
        // mid-period switch 4 -> 6
        step();
        request(6);
        check("sw_ready0", 32'(div_ready), 0);
        check("sw_div_old", 32'(active_div), 4);
        capture(14, c, t, r, b);
        check("sw_clk", c, 32'b00111000111000);
        check("sw_tick", t, 32'b00100000100000);
        check("sw_ready", r, 32'b00111111111111);
        check("sw_div6", 32'(active_div), 6);
        // illegal divisors
        request(1);
        check("err1_pulse", 32'(div_err), 1);
        check("err1_div", 32'(active_div), 6);
        check("err1_ready", 32'(div_ready), 1);
        step();
        check("err1_clear", 32'(div_err), 0);
        request(0);
        check("err0_pulse", 32'(div_err), 1);
        step();
        check("err0_clear", 32'(div_err), 0);
        check("err_clk", 32'(clock_out), 0);
        check("err_div", 32'(active_div), 6);
        step(2);
        check("err_tick", 32'(tick), 1);
        // N=5 for three periods
        request(5);
        step(5);
        check("n5_div", 32'(active_div), 5);
        check("n5_tick0", 32'(tick), 1);
        capture(15, c, t, r, b);
        check("n5_clk", c, 32'b111001110011100);
        check("n5_tick", t, 32'b100001000010000);
        // request accepted in the boundary cycle waits one more period
        step(4);
        request(4);
        check("bnd_div_hold", 32'(active_div), 5);
        check("bnd_ready0", 32'(div_ready), 0);
        step(5);
        check("bnd_div4", 32'(active_div), 4);
        check("bnd_ready1", 32'(div_ready), 1);
        request(6);
        step(3);
        check("back_div6", 32'(active_div), 6);
        // stop at counter 1 completes the period
        step();
        enable = 1'b0;
        step();
        check("stop_busy", 32'(busy), 1);
        check("stop_clk", 32'(clock_out), 1);
        capture(6, c, t, r, b);
        check("stop_clkv", c, 32'b100000);
        check("stop_busyv", b, 32'b111100);
        check("stop_tickv", t, 0);
        // restart, then cancel a stop before the boundary
        enable = 1'b1;
        step();
        check("restart_tick", 32'(tick), 1);
        step();
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        capture(9, c, t, r, b);
        check("resume_clk", c, 32'b000111000);
        check("resume_tick", t, 32'b000100000);
        check("resume_busy", b, 32'b111111111);
        // reset with an update pending
        step();
        request(7);
        check("pend_ready0", 32'(div_ready), 0);
        reset = 1'b1;
        enable = 1'b0;
        step();
        check("mrst_clk", 32'(clock_out), 0);
        check("mrst_tick", 32'(tick), 0);
        check("mrst_div", 32'(active_div), DEF);
        check("mrst_ready", 32'(div_ready), 1);
        check("mrst_busy", 32'(busy), 0);
        reset = 1'b0;
        step(2);
        check("mrst_no_apply", 32'(active_div), DEF);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Runtime controller for the team's clock divider, clocked by the 50 MHz `clock_in`.
- Sequences start and stop of the divided `clock_out`, and accepts divisor changes over a valid/ready handshake.
- New divisors take effect only on output-period boundaries, so `clock_out` never produces a runt pulse.
- Sits between the system's configuration logic and the downstream consumers of the divided clock or tick.

Parameters:
- CNT_W, 28: width of the divisor and period counter.
- DEFAULT_DIV, 50000000: divisor loaded at reset (1 Hz output from 50 MHz).
- MIN_DIV, 2: smallest legal divisor; smaller requests are rejected.

Ports:
- clock_in, input, 1: the only clock; all logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: level request to run the divided clock.
- div_valid, input, 1: divisor update request.
- div_value, input, CNT_W: requested divisor N, in clock_in cycles per clock_out period.
- div_ready, output, 1: high when the controller can accept an update.
- div_err, output, 1: one-cycle pulse when a request is rejected (N < MIN_DIV).
- clock_out, output, 1: divided clock, registered.
- tick, output, 1: one-cycle pulse coincident with each rising edge of clock_out.
- active_div, output, CNT_W: divisor currently in effect.
- busy, output, 1: high in RUN or STOP_PEND.

Behaviour:
- Reset values, applied on the clock_in edge with reset high:
  - state = IDLE, counter = 0, no pending update.
  - clock_out = 0, tick = 0, div_ready = 1, div_err = 0, busy = 0, active_div = DEFAULT_DIV.
- Reset mid-operation: clock_out drops to 0 on the next edge and any pending update is discarded.
- Waveform in RUN with divisor N:
  - Period is exactly N cycles: high for ceil(N/2) cycles, then low for floor(N/2) cycles.
  - Counter runs 0..N-1; the "boundary" is the cycle in which it wraps from N-1 to 0.
- States:
  - IDLE:
    - clock_out = 0, counter held at 0.
    - enable=1 sampled → RUN; clock_out rises and tick pulses on the next edge (1-cycle latency).
  - RUN:
    - enable=0 sampled → STOP_PEND; the current period always completes.
  - STOP_PEND:
    - Waveform continues normally.
    - At the boundary → IDLE; clock_out stays 0 and no tick is issued.
    - enable=1 sampled before the boundary → back to RUN with no gap or phase change.
- Divisor handshake:
  - Transfer occurs when div_valid && div_ready.
  - N < MIN_DIV: request is discarded; div_err pulses the next cycle; div_ready stays 1.
  - Legal N in IDLE: active_div = N on the next edge; div_ready stays 1.
  - Legal N in RUN or STOP_PEND:
    - N is stored in a shadow register and div_ready = 0 from the next cycle.
    - active_div switches at the next boundary, so the following period uses N.
    - div_ready returns to 1 the cycle after the switch.
  - If the legal request is accepted in the boundary cycle itself, it applies at the boundary after that.
  - If the controller enters IDLE with an update pending, the update is applied on the IDLE entry edge.
- Width rules:
  - Counter and divisor are unsigned CNT_W bits.
  - ceil(N/2) = N - (N>>1), computed without overflow for N = 2^CNT_W - 1.
- Simultaneous events: reset has priority over everything; enable changes and a handshake in the same cycle are handled independently.

Decomposition:
- Shared package clk_div_pkg:
  - state enum {IDLE, RUN, STOP_PEND}.
  - MIN_DIV constant.
  - CNT_W default.
- One sub-module, clk_div_core:
  - Counter and waveform generator.
  - Inputs: run, active_div.
  - Outputs: clock_out, tick, boundary.
- clk_div_ctrl owns the FSM, the handshake and the shadow register.

Test Plan:
- Reset, then N=4, enable=1: first tick 1 cycle after enable; clock_out 1100 repeating (period 80 ns); active_div=4.
- N=5, run 3 periods: high 3 cycles, low 2 cycles, tick every 5 cycles exactly.
- Running at N=4, request N=6 mid-period: div_ready=0; current period stays 4; next period 6 (3 high, 3 low); div_ready=1 the cycle after the switch.
- Request N=1 and N=0: div_err pulses once each; active_div unchanged; waveform unaffected.
- Drop enable at counter=1 of N=6: period completes, then IDLE with clock_out=0 and busy=0. Separately, reassert enable before the boundary: no gap appears.
- Assert reset at counter=2 with an update pending: next edge gives clock_out=0, active_div=DEFAULT_DIV, div_ready=1; the pending value is never applied.
